// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: FSM encoding and branch function codes.
package alu_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StResp = 2'd2
   } arb_state_e;

   localparam logic [5:0] FuncBltz = 6'b111000;
   localparam logic [5:0] FuncBgez = 6'b111001;
   localparam logic [5:0] FuncBeq  = 6'b111100;
   localparam logic [5:0] FuncBne  = 6'b111101;
   localparam logic [5:0] FuncBlez = 6'b111110;
   localparam logic [5:0] FuncBgtz = 6'b111111;

   // Class bits shared by every branch encoding.
   localparam logic [2:0] BranchClass = FuncBltz[5:3] & FuncBgez[5:3] & FuncBeq[5:3] &
                                        FuncBne[5:3] & FuncBlez[5:3] & FuncBgtz[5:3];

   function automatic logic is_branch_func(input logic [5:0] func);
      return func[5:3] == BranchClass;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-granted pointer starts at 1 so port 0 wins the first tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_q, last_d;

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last_q ? 2'b01 : 2'b10;
      end
   end

   assign last_d = (advance && (grant != 2'b00)) ? grant[1] : last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between the execute stage (port 0) and the branch unit (port 1),
// one operation in flight, response two cycles after acceptance.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned FUNC_W = 6
) (
   input  logic              Clk_in,
   input  logic              Reset_n_in,
   input  logic              Req0_valid_in,
   output logic              Req0_ready_out,
   input  logic [FUNC_W-1:0] Req0_func_in,
   input  logic [DATA_W-1:0] Req0_a_in,
   input  logic [DATA_W-1:0] Req0_b_in,
   input  logic              Req1_valid_in,
   output logic              Req1_ready_out,
   input  logic [FUNC_W-1:0] Req1_func_in,
   input  logic [DATA_W-1:0] Req1_a_in,
   input  logic [DATA_W-1:0] Req1_b_in,
   output logic [FUNC_W-1:0] Alu_func_out,
   output logic [DATA_W-1:0] Alu_a_out,
   output logic [DATA_W-1:0] Alu_b_out,
   input  logic [DATA_W-1:0] Alu_o_in,
   input  logic              Alu_branch_in,
   output logic              Rsp_valid_out,
   output logic              Rsp_id_out,
   output logic [DATA_W-1:0] Rsp_o_out,
   output logic              Rsp_branch_out,
   output logic              Rsp_is_branch_out,
   input  logic              Rsp_ready_in,
   output logic              Busy_out
);

   arb_state_e        state_q, state_d;
   logic [1:0]        req, grant;
   logic              accept, drive, op_is_branch;
   logic [FUNC_W-1:0] func_q;
   logic [DATA_W-1:0] a_q, b_q, o_q;
   logic              id_q, branch_q, is_br_q;

   // Reset gates the requests so ready drops the instant reset asserts.
   assign req    = (state_q == StIdle && Reset_n_in) ? {Req1_valid_in, Req0_valid_in} : 2'b00;
   assign accept = |grant;

   rr_arb2 u_arb (
      .clk    (Clk_in),
      .rst_n  (Reset_n_in),
      .req    (req),
      .advance(accept),
      .grant  (grant)
   );

   assign Req0_ready_out = grant[0];
   assign Req1_ready_out = grant[1];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StExec;
         StExec:  state_d = StResp;
         StResp:  if (Rsp_ready_in) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk_in or negedge Reset_n_in) begin
      if (!Reset_n_in) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   assign op_is_branch = is_branch_func(func_q[5:0]);

   always_ff @(posedge Clk_in or negedge Reset_n_in) begin
      if (!Reset_n_in) begin
         func_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         id_q     <= 1'b0;
         o_q      <= '0;
         branch_q <= 1'b0;
         is_br_q  <= 1'b0;
      end else begin
         if (accept) begin
            func_q <= grant[1] ? Req1_func_in : Req0_func_in;
            a_q    <= grant[1] ? Req1_a_in    : Req0_a_in;
            b_q    <= grant[1] ? Req1_b_in    : Req0_b_in;
            id_q   <= grant[1];
         end
         if (state_q == StExec) begin
            o_q      <= Alu_o_in;
            is_br_q  <= op_is_branch;
            branch_q <= Alu_branch_in & op_is_branch;
         end
      end
   end

   assign drive        = (state_q != StIdle);
   assign Alu_func_out = drive ? func_q : '0;
   assign Alu_a_out    = drive ? a_q : '0;
   assign Alu_b_out    = drive ? b_q : '0;
   assign Busy_out     = drive;

   assign Rsp_valid_out     = (state_q == StResp);
   assign Rsp_id_out        = id_q;
   assign Rsp_o_out         = o_q;
   assign Rsp_branch_out    = branch_q;
   assign Rsp_is_branch_out = is_br_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed corner cases then random traffic against a
// cycle-level reference model, with an independent response monitor.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int DW = 32;
   localparam int FW = 6;

   logic          Clk_in = 1'b0;
   logic          Reset_n_in = 1'b0;
   logic          Req0_valid_in, Req0_ready_out, Req1_valid_in, Req1_ready_out;
   logic [FW-1:0] Req0_func_in, Req1_func_in, Alu_func_out;
   logic [DW-1:0] Req0_a_in, Req0_b_in, Req1_a_in, Req1_b_in;
   logic [DW-1:0] Alu_a_out, Alu_b_out, Alu_o_in, Rsp_o_out;
   logic          Alu_branch_in, Rsp_valid_out, Rsp_id_out, Rsp_branch_out, Rsp_is_branch_out;
   logic          Rsp_ready_in, Busy_out;

   alu_arbiter #(.DATA_W(DW), .FUNC_W(FW)) dut (
      .Clk_in           (Clk_in),
      .Reset_n_in       (Reset_n_in),
      .Req0_valid_in    (Req0_valid_in),
      .Req0_ready_out   (Req0_ready_out),
      .Req0_func_in     (Req0_func_in),
      .Req0_a_in        (Req0_a_in),
      .Req0_b_in        (Req0_b_in),
      .Req1_valid_in    (Req1_valid_in),
      .Req1_ready_out   (Req1_ready_out),
      .Req1_func_in     (Req1_func_in),
      .Req1_a_in        (Req1_a_in),
      .Req1_b_in        (Req1_b_in),
      .Alu_func_out     (Alu_func_out),
      .Alu_a_out        (Alu_a_out),
      .Alu_b_out        (Alu_b_out),
      .Alu_o_in         (Alu_o_in),
      .Alu_branch_in    (Alu_branch_in),
      .Rsp_valid_out    (Rsp_valid_out),
      .Rsp_id_out       (Rsp_id_out),
      .Rsp_o_out        (Rsp_o_out),
      .Rsp_branch_out   (Rsp_branch_out),
      .Rsp_is_branch_out(Rsp_is_branch_out),
      .Rsp_ready_in     (Rsp_ready_in),
      .Busy_out         (Busy_out)
   );

   initial forever #5 Clk_in = ~Clk_in;

   typedef struct {
      logic          id;
      logic [DW-1:0] o;
      logic          br;
      logic          isb;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Stimulus state, applied to the DUT on each falling edge.
   logic [1:0]    p_valid;
   logic [FW-1:0] p_func[2];
   logic [DW-1:0] p_a[2], p_b[2];
   logic          rsp_rdy, rst_drv, force_br;

   // Reference model state.
   bit            outstanding;
   int            rsp_cycle;
   int            cyc;
   bit            last_id;
   logic [FW-1:0] cur_func;
   logic [DW-1:0] cur_a, cur_b;
   logic [1:0]    acc;

   // Behavioural stand-in for the external ALU.
   function automatic logic [DW-1:0] model_o(input logic [FW-1:0] f, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      if (f[5:3] == 3'b111) return a - b;
      return (a + b) ^ {{(DW-FW){1'b0}}, f};
   endfunction

   function automatic logic model_br(input logic [FW-1:0] f, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
      case (f)
         FuncBltz: return $signed(a) < 0;
         FuncBgez: return $signed(a) >= 0;
         FuncBeq:  return a == b;
         FuncBne:  return a != b;
         FuncBlez: return $signed(a) <= 0;
         FuncBgtz: return $signed(a) > 0;
         default:  return 1'b0;
      endcase
   endfunction

   assign Alu_o_in      = model_o(Alu_func_out, Alu_a_out, Alu_b_out);
   assign Alu_branch_in = force_br | model_br(Alu_func_out, Alu_a_out, Alu_b_out);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, req);
      end
   endtask

   task automatic zero_checks(input string tag);
      chk({tag, "_ready"}, {62'd0, Req1_ready_out, Req0_ready_out}, 64'd0);
      chk({tag, "_rsp_valid"}, {63'd0, Rsp_valid_out}, 64'd0);
      chk({tag, "_rsp_id"}, {63'd0, Rsp_id_out}, 64'd0);
      chk({tag, "_rsp_o"}, {32'd0, Rsp_o_out}, 64'd0);
      chk({tag, "_rsp_branch"}, {62'd0, Rsp_branch_out, Rsp_is_branch_out}, 64'd0);
      chk({tag, "_busy"}, {63'd0, Busy_out}, 64'd0);
      chk({tag, "_alu_drive"}, {26'd0, Alu_func_out, Alu_a_out | Alu_b_out}, 64'd0);
   endtask

   // One clock cycle: drive inputs, then predict and check this cycle's handshake outcome.
   task automatic tick();
      logic [1:0] g;
      bit         idle, exp_rv, win;
      exp_t       e;
      @(negedge Clk_in);
      Reset_n_in    = rst_drv;
      Req0_valid_in = p_valid[0];
      Req0_func_in  = p_func[0];
      Req0_a_in     = p_a[0];
      Req0_b_in     = p_b[0];
      Req1_valid_in = p_valid[1];
      Req1_func_in  = p_func[1];
      Req1_a_in     = p_a[1];
      Req1_b_in     = p_b[1];
      Rsp_ready_in  = rsp_rdy;
      #1;
      cyc++;
      acc = 2'b00;
      if (!rst_drv) begin
         zero_checks("in_reset");
         outstanding = 0;
         last_id     = 1;
         exp_q.delete();
         return;
      end
      idle = !outstanding;
      g    = 2'b00;
      if (idle && p_valid != 2'b00) begin
         if (p_valid == 2'b11) win = !last_id;
         else win = p_valid[1];
         g[win] = 1'b1;
      end
      exp_rv = outstanding && (cyc >= rsp_cycle);
      chk("ready", {62'd0, Req1_ready_out, Req0_ready_out}, {62'd0, g});
      chk("busy", {63'd0, Busy_out}, {63'd0, !idle});
      chk("rsp_valid", {63'd0, Rsp_valid_out}, {63'd0, exp_rv});
      if (idle) chk("alu_idle", {26'd0, Alu_func_out, Alu_a_out | Alu_b_out}, 64'd0);
      else chk("alu_drive", {Alu_func_out, Alu_a_out ^ Alu_b_out, 26'd0},
               {cur_func, cur_a ^ cur_b, 26'd0});
      if (!idle) chk("alu_a", {32'd0, Alu_a_out}, {32'd0, cur_a});
      if (exp_rv && rsp_rdy) outstanding = 0;
      if (g != 2'b00) begin
         win         = g[1];
         cur_func    = p_func[win];
         cur_a       = p_a[win];
         cur_b       = p_b[win];
         e.id        = win;
         e.o         = model_o(cur_func, cur_a, cur_b);
         e.isb       = (cur_func[5:3] == 3'b111);
         e.br        = e.isb && (force_br || model_br(cur_func, cur_a, cur_b));
         exp_q.push_back(e);
         outstanding = 1;
         rsp_cycle   = cyc + 2;
         last_id     = win;
      end
      acc = g;
   endtask

   task automatic drain();
      rsp_rdy = 1'b1;
      for (int i = 0; i < 20 && outstanding; i++) tick();
   endtask

   task automatic run_op(input int port, input logic [FW-1:0] f, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
      p_valid[port] = 1'b1;
      p_func[port]  = f;
      p_a[port]     = a;
      p_b[port]     = b;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (acc[port]) break;
      end
      p_valid[port] = 1'b0;
      drain();
   endtask

   function automatic logic [DW-1:0] rand_operand();
      case ($urandom_range(3))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [FW-1:0] rand_func();
      logic [FW-1:0] f;
      f = FW'($urandom);
      if ($urandom_range(1) == 1) f[5:3] = 3'b111;
      return f;
   endfunction

   // Response monitor: every presented response must match the oldest expected one.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk_in);
         #2;
         if (Rsp_valid_out) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", {63'd0, Rsp_valid_out}, 64'd0);
            end else begin
               e = exp_q[0];
               chk("rsp_id", {63'd0, Rsp_id_out}, {63'd0, e.id});
               chk("rsp_o", {32'd0, Rsp_o_out}, {32'd0, e.o});
               chk("rsp_is_branch", {63'd0, Rsp_is_branch_out}, {63'd0, e.isb});
               chk("rsp_branch", {63'd0, Rsp_branch_out}, {63'd0, e.br});
               if (Rsp_ready_in) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic       g_ids[$];
      logic [3:0] alt;
      p_valid     = 2'b00;
      for (int i = 0; i < 2; i++) begin
         p_func[i] = '0;
         p_a[i]    = '0;
         p_b[i]    = '0;
      end
      rsp_rdy     = 1'b1;
      rst_drv     = 1'b0;
      force_br    = 1'b0;
      outstanding = 0;
      last_id     = 1;
      cyc         = 0;
      cur_func    = '0;
      cur_a       = '0;
      cur_b       = '0;
      Req0_valid_in = 0; Req1_valid_in = 0; Rsp_ready_in = 1;
      Req0_func_in = '0; Req0_a_in = '0; Req0_b_in = '0;
      Req1_func_in = '0; Req1_a_in = '0; Req1_b_in = '0;

      tick();
      tick();
      rst_drv = 1'b1;

      // Port 1 BEQ 0,0: taken branch, response two cycles after acceptance.
      run_op(1, FuncBeq, '0, '0);
      // BNE then BEQ with unequal operands.
      run_op(0, FuncBne, '0, 32'd1);
      run_op(0, FuncBeq, '0, 32'd1);
      // Non-branch op with the ALU asserting branch: must be masked.
      force_br = 1'b1;
      run_op(0, 6'b000001, 32'd5, 32'd7);
      force_br = 1'b0;

      // BLTZ on port 1 with response back-pressured while port 0 keeps asking.
      p_valid  = 2'b11;
      p_func[0] = 6'b000100; p_a[0] = 32'd3;         p_b[0] = 32'd4;
      p_func[1] = FuncBltz;  p_a[1] = 32'hFFFF_FFFF; p_b[1] = '0;
      rsp_rdy  = 1'b0;
      tick();
      chk("tie_grant_port1", {62'd0, acc}, 64'd2);
      p_valid[1] = 1'b0;
      repeat (7) tick();
      rsp_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (acc[0]) break;
      end
      p_valid[0] = 1'b0;
      drain();

      // Both ports continuously valid straight out of reset: grants alternate.
      rst_drv = 1'b0;
      tick();
      rst_drv = 1'b1;
      p_valid = 2'b11;
      for (int k = 0; k < 14; k++) begin
         tick();
         if (acc != 2'b00) begin
            g_ids.push_back(acc[1]);
            p_func[acc[1]] = rand_func();
            p_a[acc[1]]    = rand_operand();
         end
      end
      p_valid = 2'b00;
      drain();
      alt = 4'b1010;
      chk("alt_grant_count", {63'd0, g_ids.size() >= 4}, 64'd1);
      for (int k = 0; k < 4 && k < g_ids.size(); k++)
         chk("alt_grant_seq", {63'd0, g_ids[k]}, {63'd0, alt[k]});

      // Reset asserted mid-EXEC after a port-0 grant.
      p_valid = 2'b01;
      p_func[0] = 6'b000010; p_a[0] = 32'h1234; p_b[0] = 32'h10;
      tick();
      p_valid = 2'b00;
      tick();
      #2;
      Req0_valid_in = 1'b1;
      Req1_valid_in = 1'b1;
      Reset_n_in    = 1'b0;
      #1;
      zero_checks("async_reset");
      outstanding = 0;
      last_id     = 1;
      exp_q.delete();
      rst_drv = 1'b0;
      p_valid = 2'b11;
      tick();
      rst_drv = 1'b1;
      tick();
      chk("post_reset_grant", {62'd0, acc}, 64'd1);
      p_valid = 2'b00;
      drain();

      // Randomised traffic, including operand changes while waiting.
      for (int it = 0; it < 400; it++) begin
         for (int p = 0; p < 2; p++) begin
            if (!p_valid[p]) begin
               if ($urandom_range(1) == 1) begin
                  p_valid[p] = 1'b1;
                  p_func[p]  = rand_func();
                  p_a[p]     = rand_operand();
                  p_b[p]     = rand_operand();
               end
            end else if ($urandom_range(3) == 0) begin
               p_a[p]    = rand_operand();
               p_func[p] = rand_func();
            end
         end
         rsp_rdy = ($urandom_range(2) != 0);
         if (!outstanding) force_br = ($urandom_range(3) == 0);
         tick();
         if (acc[0]) p_valid[0] = 1'b0;
         if (acc[1]) p_valid[1] = 1'b0;
      end
      p_valid = 2'b00;
      drain();
      force_br = 1'b0;
      repeat (3) tick();
      chk("all_responses_seen", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the operand and result width.
REQ-002 SHALL have parameter FUNC_W, default 6, meaning the ALU function-code width.
REQ-003 SHALL have port Clk_in, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports Req0_valid_in, input, 1 bit, and Req0_ready_out, output, 1 bit: the execute-stage request handshake.
REQ-006 SHALL have ports Req0_func_in (FUNC_W), Req0_a_in (DATA_W) and Req0_b_in (DATA_W), all inputs: the execute-stage operation.
REQ-007 SHALL have ports Req1_valid_in, Req1_ready_out, Req1_func_in, Req1_a_in and Req1_b_in: the branch-unit request, with the same widths as port 0.
REQ-008 SHALL have outputs Alu_func_out (FUNC_W), Alu_a_out (DATA_W) and Alu_b_out (DATA_W): the drive to the shared ALU_32BIT.
REQ-009 SHALL have inputs Alu_o_in (DATA_W) and Alu_branch_in (1 bit): the combinational result from ALU_32BIT.
REQ-010 SHALL have outputs Rsp_valid_out (1), Rsp_id_out (1), Rsp_o_out (DATA_W), Rsp_branch_out (1) and Rsp_is_branch_out (1), plus input Rsp_ready_in (1): the response channel.
REQ-011 SHALL have output Busy_out, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement an FSM with states IDLE, EXEC and RESP; only one operation is in flight at a time.
REQ-013 SHALL assert ReqN_ready_out only in IDLE, and only for the granted port; a transfer is valid && ready in the same cycle.
REQ-014 SHALL grant by round-robin when both ports are valid: the port not granted last wins; the last-grant pointer resets to 1, so port 0 wins the first tie.
REQ-015 SHALL grant a lone valid requester immediately, regardless of the pointer.
REQ-016 SHALL, on acceptance in cycle N, register the function code, A, B and the granted id, and move to EXEC in cycle N+1.
REQ-017 SHALL hold Alu_func_out, Alu_a_out and Alu_b_out equal to the registered operation throughout EXEC and RESP.
REQ-018 SHALL, in EXEC, capture Alu_o_in and Alu_branch_in into the response registers and enter RESP.
REQ-019 SHALL assert Rsp_valid_out from cycle N+2, giving 2-cycle latency from acceptance to response.
REQ-020 SHALL hold Rsp_valid_out and all Rsp_* outputs stable in RESP until Rsp_ready_in is high, then return to IDLE.
REQ-021 SHALL allow a new request to be accepted no earlier than the cycle after the response completes; throughput with no back-pressure is one operation per 3 cycles.
REQ-022 SHALL set Rsp_is_branch_out = 1 when func[5:3] == 3'b111 (BLTZ, BGEZ, BEQ, BNE, BLEZ, BGTZ).
REQ-023 SHALL force Rsp_branch_out = 0 when Rsp_is_branch_out = 0.
REQ-024 SHALL drive Alu_func_out = 0, Alu_a_out = 0 and Alu_b_out = 0 in IDLE.
REQ-025 SHALL ignore request changes that occur while the port is not ready; only the values present at the transfer are used.
REQ-026 SHALL guarantee no starvation: a continuously valid requester is granted within 2 grants.

Reset
REQ-027 SHALL, on reset assertion, asynchronously force: state = IDLE; all ready outputs = 0; Rsp_valid_out = 0; Rsp_id_out = 0; Rsp_o_out = 0; Rsp_branch_out = 0; Rsp_is_branch_out = 0; Busy_out = 0; ALU drive = 0; pointer = 1.
REQ-028 SHALL discard any in-flight operation when reset asserts mid-EXEC or mid-RESP; no response is produced after release.
REQ-029 SHALL permit the first acceptance on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL take the FSM state encodings and the branch function codes (111000, 111001, 111100, 111101, 111110, 111111) from a shared package, alu_pkg.
REQ-031 SHALL factor the 2-way round-robin arbiter into the sub-module rr_arb2 (inputs req[1:0] and advance; output one-hot grant).
REQ-032 SHALL instantiate the ALU outside this block; the arbiter contains no arithmetic.

Verification
REQ-033 SHALL cover: port 1 only, func 111100, A = 0, B = 0 -> Rsp_valid at N+2, id = 1, is_branch = 1, branch = 1.
REQ-034 SHALL cover: both ports valid continuously after reset -> grants alternate 0, 1, 0, 1; Rsp_id sequence 0, 1, 0, 1.
REQ-035 SHALL cover: port 1, func 111000, A = 0xFFFFFFFF -> branch = 1; Rsp_ready_in held low 5 cycles -> Rsp_* stable, no new grant, Busy_out = 1.
REQ-036 SHALL cover: port 0, func 111101, A = 0, B = 1 -> branch = 1; then func 111100 with the same operands -> branch = 0.
REQ-037 SHALL cover: reset pulsed during EXEC -> all outputs 0 immediately, no response after release, next request granted to port 0.
REQ-038 SHALL cover: a non-branch func with Alu_branch_in forced to 1 by the ALU model -> Rsp_branch_out = 0, Rsp_o_out = Alu_o_in.
